// File: rtl/gelato_issue_arbiter.sv
// ---------------------------------------------------------------------------
// gelato_issue_arbiter
//
// Round-robin arbiter that sits between NUM_REQ operand-collector units and a
// single execute unit on the issue path. Each cycle at most one collector with
// an issuable instruction is granted. The winner's instruction and source
// operands are captured in a one-entry output stage that feeds the execute
// unit. A saturating counter records how many cycles the output stage was
// stalled by the execute unit.
//
// Ports
//   clk        : clock
//   rst_n      : synchronous active-low reset
//   rdy        : global enable, 0 blocks new grants (a pending entry may drain)
//   req_valid  : per-collector "instruction ready to issue"
//   req_ready  : one-hot grant, collector i is consumed this cycle
//   req_inst   : packed instructions, collector i at [i*INST_W +: INST_W]
//   req_src    : packed sources, collector i src j at [(i*NUM_SRC+j)*SRC_W +: SRC_W]
//   out_valid  : output stage holds an instruction for the execute unit
//   out_ready  : execute unit accepts the output stage this cycle
//   out_inst   : registered instruction
//   out_src    : registered source operands
//   out_id     : index of the collector that supplied the output stage
//   stall_cnt  : saturating count of cycles with out_valid && !out_ready
// ---------------------------------------------------------------------------
module gelato_issue_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int INST_W  = 64,
    parameter int SRC_W   = 32,
    parameter int NUM_SRC = 3,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             rdy,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*INST_W-1:0]        req_inst,
    input  logic [NUM_REQ*NUM_SRC*SRC_W-1:0] req_src,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [INST_W-1:0]                out_inst,
    output logic [NUM_SRC*SRC_W-1:0]         out_src,
    output logic [ID_W-1:0]                  out_id,
    output logic [31:0]                      stall_cnt
);

    localparam int SRCS_W = NUM_SRC * SRC_W;

    logic                  out_valid_q, out_valid_d;
    logic [INST_W-1:0]     out_inst_q,  out_inst_d;
    logic [SRCS_W-1:0]     out_src_q,   out_src_d;
    logic [ID_W-1:0]       out_id_q,    out_id_d;
    logic [ID_W-1:0]       rr_ptr_q,    rr_ptr_d;
    logic [31:0]           stall_cnt_q, stall_cnt_d;

    logic                  can_load;
    logic                  grant_found;
    logic                  grant_en;
    logic [ID_W-1:0]       grant_id;
    logic [ID_W-1:0]       scan_id;
    int                    scan_idx;
    logic [INST_W-1:0]     sel_inst;
    logic [SRCS_W-1:0]     sel_src;

    // The output stage may take a new entry when it is empty or its current
    // entry is being accepted in the same cycle, which gives back-to-back issue.
    assign can_load = !out_valid_q || out_ready;

    // Round-robin search starting at rr_ptr and wrapping modulo NUM_REQ; the
    // first valid requester encountered wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = 0;
        scan_id     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            scan_id = ID_W'(scan_idx);
            if (!grant_found && req_valid[scan_id]) begin
                grant_found = 1'b1;
                grant_id    = scan_id;
            end
        end
    end

    // Grant qualification deliberately ignores instruction/source data so the
    // handshake never has a combinational path from the payload.
    assign grant_en  = rst_n && rdy && can_load && grant_found;
    assign req_ready = grant_en ? (NUM_REQ'(1) << grant_id) : '0;

    // Payload mux built from constant slices of the packed request buses.
    always_comb begin
        sel_inst = '0;
        sel_src  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant_id) begin
                sel_inst = req_inst[i*INST_W +: INST_W];
                sel_src  = req_src[i*SRCS_W +: SRCS_W];
            end
        end
    end

    // Next-state for the output stage, round-robin pointer and stall counter.
    // When the stage cannot load everything holds, so a stalled entry stays
    // stable until the execute unit takes it.
    always_comb begin
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_src_d   = out_src_q;
        out_id_d    = out_id_q;
        rr_ptr_d    = rr_ptr_q;
        stall_cnt_d = stall_cnt_q;

        if (can_load) begin
            if (grant_en) begin
                out_valid_d = 1'b1;
                out_inst_d  = sel_inst;
                out_src_d   = sel_src;
                out_id_d    = grant_id;
                if (int'(grant_id) == NUM_REQ - 1) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = grant_id + ID_W'(1);
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end

        if (out_valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // State registers with synchronous active-low reset; a pending entry is
    // simply dropped on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_src_q   <= '0;
            out_id_q    <= '0;
            rr_ptr_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_src_q   <= out_src_d;
            out_id_q    <= out_id_d;
            rr_ptr_q    <= rr_ptr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign out_src   = out_src_q;
    assign out_id    = out_id_q;
    assign stall_cnt = stall_cnt_q;

endmodule
